// File: rtl/cc_cycle_acquirer_if.sv
// rtl/cc_cycle_acquirer_if.sv - result handshake bus of the coincidence cycle acquirer
// master drives valid and the summed results; slave returns ready.
interface cc_cycle_acquirer_if #(
    parameter int ACC_W = 32
) ();
    logic             res_valid_op;
    logic             res_ready_ip;
    logic [ACC_W-1:0] res_total_op;
    logic [ACC_W-1:0] res_ra_op;
    logic [ACC_W-1:0] res_a_op;
    logic [7:0]       res_cycles_op;

    modport master (
        output res_valid_op, res_total_op, res_ra_op, res_a_op, res_cycles_op,
        input  res_ready_ip
    );

    modport slave (
        input  res_valid_op, res_total_op, res_ra_op, res_a_op, res_cycles_op,
        output res_ready_ip
    );
endinterface

// File: rtl/cc_cycle_acquirer.sv
// rtl/cc_cycle_acquirer.sv - sums coincidence-counter deltas over N contiguous windows
// Channel index 0 = total, 1 = R+A, 2 = A throughout.
module cc_cycle_acquirer #(
    parameter int CNT_W          = 13,
    parameter int ACC_W          = 32,
    parameter int COUNT_TIME     = 1000000,
    parameter int TIME_W         = 20,
    parameter int STABLE_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset_ip,
    input  logic                 start_ip,
    input  logic                 abort_ip,
    input  logic [7:0]           n_cycles_ip,
    input  logic [CNT_W-1:0]     total_count_ip,
    input  logic [CNT_W-1:0]     ra_count_ip,
    input  logic [CNT_W-1:0]     a_count_ip,
    cc_cycle_acquirer_if.master  res_if,
    output logic                 busy_op,
    output logic                 overflow_op
);
    localparam int WAIT_W = $clog2(STABLE_TIMEOUT + 1);
    localparam int SUM_W  = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STABLE_TIMEOUT - 1);
    localparam logic [TIME_W-1:0] TIME_LAST = TIME_W'(COUNT_TIME - 1);
    localparam logic [SUM_W-1:0]  ACC_MAX   = SUM_W'({ACC_W{1'b1}});

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNAP0 = 3'd1,
        COUNT = 3'd2,
        SNAP1 = 3'd3,
        ACCUM = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                      state_q, state_d;
    logic [2:0][CNT_W-1:0]       s1_q, s2_q, s3_q;
    logic [2:0][CNT_W-1:0]       base_q, end_q;
    logic [2:0][ACC_W-1:0]       acc_q;
    logic [7:0]                  n_q, cycles_q;
    logic [TIME_W-1:0]           timer_q;
    logic [WAIT_W-1:0]           wait_q;
    logic                        valid_q, busy_q, ovf_q;

    logic                        snap_ok;
    logic                        timer_last;
    logic                        abort_hit;
    logic [7:0]                  cycles_inc;
    logic [2:0][CNT_W-1:0]       diff;
    logic [2:0][SUM_W-1:0]       sum;
    logic [2:0][ACC_W-1:0]       acc_nxt;
    logic                        sat_any;

    // The counter lives in another clock domain; s2 only counts as stable
    // when it matched s3 on every channel, i.e. no bit was mid-transition.
    assign snap_ok    = (s2_q == s3_q) || (wait_q == WAIT_LAST);
    assign timer_last = (timer_q == TIME_LAST);
    assign abort_hit  = abort_ip && (state_q != IDLE);
    assign cycles_inc = cycles_q + 8'd1;

    always_comb begin
        diff    = '0;
        sum     = '0;
        acc_nxt = '0;
        sat_any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // Modulo subtraction absorbs a counter wrap within one window.
            diff[i] = end_q[i] - base_q[i];
            sum[i]  = SUM_W'(acc_q[i]) + SUM_W'(diff[i]);
            if (sum[i] > ACC_MAX) begin
                acc_nxt[i] = '1;
                sat_any    = 1'b1;
            end else begin
                acc_nxt[i] = sum[i][ACC_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_hit) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_ip && (n_cycles_ip != 8'd0)) state_d = SNAP0;
                SNAP0:   if (snap_ok) state_d = COUNT;
                COUNT:   if (timer_last) state_d = SNAP1;
                SNAP1:   if (snap_ok) state_d = ACCUM;
                ACCUM:   state_d = (cycles_inc == n_q) ? DONE : COUNT;
                DONE:    if (res_if.res_ready_ip) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_ip) begin
        if (reset_ip) begin
            state_q  <= IDLE;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            base_q   <= '0;
            end_q    <= '0;
            acc_q    <= '0;
            n_q      <= '0;
            cycles_q <= '0;
            timer_q  <= '0;
            wait_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            valid_q <= (state_d == DONE);
            s1_q    <= {a_count_ip, ra_count_ip, total_count_ip};
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            if (abort_hit) begin
                acc_q    <= '0;
                cycles_q <= '0;
                ovf_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_ip && (n_cycles_ip != 8'd0)) begin
                            n_q      <= n_cycles_ip;
                            acc_q    <= '0;
                            cycles_q <= '0;
                            ovf_q    <= 1'b0;
                            wait_q   <= '0;
                        end
                    end
                    SNAP0: begin
                        if (snap_ok) begin
                            base_q  <= s2_q;
                            timer_q <= '0;
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
                    end
                    COUNT: begin
                        if (timer_last) wait_q  <= '0;
                        else            timer_q <= timer_q + 1'b1;
                    end
                    SNAP1: begin
                        if (snap_ok) end_q  <= s2_q;
                        else         wait_q <= wait_q + 1'b1;
                    end
                    ACCUM: begin
                        acc_q    <= acc_nxt;
                        if (sat_any) ovf_q <= 1'b1;
                        cycles_q <= cycles_inc;
                        // Next window starts exactly where this one ended.
                        base_q   <= end_q;
                        timer_q  <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign res_if.res_valid_op  = valid_q;
    assign res_if.res_total_op  = acc_q[0];
    assign res_if.res_ra_op     = acc_q[1];
    assign res_if.res_a_op      = acc_q[2];
    assign res_if.res_cycles_op = cycles_q;
    assign busy_op              = busy_q;
    assign overflow_op          = ovf_q;
endmodule
